adding_machine_sequencer: RTL and testbench

Controller that drives the adding machine's 256-word instruction/data ROM. On a start request, it walks ROM addresses from a supplied base and accumulates each fetched 32-bit word into a running sum. It stops on a zero sentinel word or after a word limit, then reports sum, count and overflow. It sits between the top-level adding machine and its ROM, and owns the ROM address bus.

---
 rtl/adding_machine_sequencer.sv | 83 ++++++++
 tb/tb_adding_machine_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adding_machine_sequencer.sv
// ROM walker for the adding machine: accumulates words from base_addr until a zero or MAX_WORDS.
// Build option: define AM_SATURATE_EN to clamp the sum at 0xFFFFFFFF on carry-out.
module adding_machine_sequencer #(
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [29:0] base_addr,
    output logic [29:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] sum,
    output logic [8:0]  count,
    output logic        overflow
);

    typedef enum logic [1:0] {StIdle, StFetch, StRead, StDone} state_t;

    localparam logic [8:0] MaxCount = 9'(MAX_WORDS);

    state_t      state;
    logic [32:0] add_full;
    logic [8:0]  count_inc;

    assign add_full  = {1'b0, sum} + {1'b0, rom_data};
    assign count_inc = count + 9'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= StIdle;
            rom_addr <= '0;
            sum      <= '0;
            count    <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        rom_addr <= base_addr;
                        sum      <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        state    <= StFetch;
                    end
                end
                StFetch: state <= StRead;
                StRead: begin
                    if (rom_data == 32'd0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end else begin
`ifdef AM_SATURATE_EN
                        // Once saturated, any further nonzero word carries again, so it stays clamped.
                        sum <= add_full[32] ? 32'hFFFF_FFFF : add_full[31:0];
`else
                        sum <= add_full[31:0];
`endif
                        if (add_full[32]) overflow <= 1'b1;
                        count    <= count_inc;
                        rom_addr <= rom_addr + 30'd1;
                        if (count_inc == MaxCount) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= StDone;
                        end else begin
                            state <= StFetch;
                        end
                    end
                end
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_adding_machine_sequencer.sv
// Scoreboard bench for adding_machine_sequencer: directed scenarios plus randomized ROM runs.
// Honours AM_SATURATE_EN in its reference model.
module tb_adding_machine_sequencer;

    localparam int unsigned MAX_W = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [29:0] base_addr = '0;
    logic [29:0] rom_addr;
    logic [31:0] rom_data;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic [8:0]  count;
    logic        overflow;

    logic [31:0] rom [256];
    assign rom_data = rom[rom_addr[7:0]];

    adding_machine_sequencer #(.MAX_WORDS(MAX_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] sum;
        int          count;
        logic        ovf;
        logic [29:0] addr;
        int          done_cyc;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: walk the ROM word by word with wide arithmetic; returns results and read count.
    function automatic exp_t model(input logic [29:0] b, output int reads);
        exp_t e;
        longint unsigned t;
        logic [31:0] w;
        logic [29:0] a = b;
        e.sum = 0; e.count = 0; e.ovf = 0; e.done_cyc = 0;
        reads = 0;
        for (int i = 0; i < 300; i++) begin
            w = rom[a[7:0]];
            reads++;
            if (w == 0) break;
            t = longint'(e.sum) + longint'(w);
            if (t > 64'h0000_0000_FFFF_FFFF) e.ovf = 1'b1;
`ifdef AM_SATURATE_EN
            e.sum = (t > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : t[31:0];
`else
            e.sum = t[31:0];
`endif
            e.count++;
            a = a + 30'd1;
            if (e.count == int'(MAX_W)) break;
        end
        e.addr = a;
        return e;
    endfunction

    // Monitor: every done pulse retires one expected run.
    always @(negedge clock) begin
        if (done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sum", 64'(sum), 64'(e.sum));
                check("count", 64'(count), 64'(e.count));
                check("overflow", 64'(overflow), 64'(e.ovf));
                check("rom_addr_final", 64'(rom_addr), 64'(e.addr));
                check("done_edge", 64'(cyc), 64'(e.done_cyc));
                check("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    // Launch a run; done is due 2 edges per ROM read after the edge that samples start.
    task automatic launch(input logic [29:0] b, output exp_t e);
        int reads;
        @(negedge clock);
        start = 1'b1;
        base_addr = b;
        e = model(b, reads);
        @(posedge clock);
        #1;
        e.done_cyc = cyc + 2 * reads;
        check("busy_after_start", 64'(busy), 64'd1);
        check("rom_addr_base", 64'(rom_addr), 64'(b));
        q.push_back(e);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clock);
        if (q.size() != 0) begin
            check("done_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
        @(negedge clock);
        check("busy_after_done", 64'(busy), 64'd0);
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rom_addr"}, 64'(rom_addr), 64'd0);
        check({tag, "_sum"}, 64'(sum), 64'd0);
        check({tag, "_count"}, 64'(count), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    task automatic set_1230();
        for (int i = 0; i < 256; i++) rom[i] = 32'd7;
        rom[0] = 1; rom[1] = 2; rom[2] = 3; rom[3] = 0;
    endtask

    initial begin
        exp_t e;
        for (int i = 0; i < 256; i++) rom[i] = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        check_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        set_1230();
        launch(30'd0, e);
        wait_idle();

        rom[0] = 32'hFFFF_FFFF; rom[1] = 2; rom[2] = 0;
        launch(30'd0, e);
        wait_idle();

        for (int i = 0; i < 256; i++) rom[i] = 32'd1;
        launch(30'd254, e);
        wait_idle();

        rom[5] = 0;
        launch(30'd5, e);
        wait_idle();

        // Start while busy must be ignored.
        set_1230();
        launch(30'd0, e);
        start = 1'b1; base_addr = 30'd100;
        @(negedge clock);
        start = 1'b0;
        wait_idle();

        // Reset sampled at edge 4 of a run abandons it.
        launch(30'd0, e);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        q.delete();
        check_zero("midrun_reset");
        @(negedge clock);
        reset = 1'b0;
        repeat (12) @(negedge clock);
        check("no_done_after_reset", 64'(sum), 64'd0);

        // Reset wins over simultaneous start.
        start = 1'b1; reset = 1'b1;
        @(posedge clock);
        #1;
        check_zero("reset_start");
        @(negedge clock);
        start = 1'b0; reset = 1'b0;

        launch(30'd0, e);
        wait_idle();

        for (int r = 0; r < 40; r++) begin
            logic [29:0] b;
            for (int i = 0; i < 256; i++) begin
                case ($urandom_range(0, 3))
                    0: rom[i] = 32'd0;
                    1: rom[i] = $urandom_range(1, 1000);
                    2: rom[i] = $urandom | 32'd1;
                    default: rom[i] = 32'hF000_0000 | $urandom;
                endcase
            end
            b = 30'($urandom);
            if (r % 8 == 0) b = 30'h3FFF_FFFE;
            launch(b, e);
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
